// File: rtl/deskew_matrix_pkg.sv
// Shared types and sizing helpers for the matrix deskew block.
package deskew_matrix_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      DONE    = 1'b1
   } state_t;

   // Number of skewed wavefront beats that make up one SIZE x SIZE frame.
   function automatic int beats(input int size);
      return 2 * size - 1;
   endfunction

   // Bit offset of lane t inside a packed beat.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/deskew_matrix_if.sv
// Beat-in / matrix-out handshake bundle for deskew_matrix.
interface deskew_matrix_if #(
   parameter int WIDTH = 4,
   parameter int SIZE  = 3
);
   logic                                  in_valid;
   logic                                  in_ready;
   logic [SIZE*WIDTH-1:0]                 in_beat;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  Mout;
   logic                                  frame_err;

   modport master (
      output in_valid, in_beat, out_ready,
      input  in_ready, out_valid, Mout, frame_err
   );

   modport slave (
      input  in_valid, in_beat, out_ready,
      output in_ready, out_valid, Mout, frame_err
   );
endinterface

// File: rtl/deskew_matrix_lane.sv
// One lane of the deskewer: owns matrix row LANE, captures its live beats
// into the right column and flags nonzero data on dead slots.
module deskew_matrix_lane #(
   parameter int WIDTH = 4,
   parameter int SIZE  = 3,
   parameter int LANE  = 0,
   parameter int CW    = 3
) (
   input  logic                        clock,
   input  logic                        nreset,
   input  logic                        accept,
   input  logic [CW-1:0]               beat,
   input  logic [WIDTH-1:0]            lane_data,
   output logic [SIZE-1:0][WIDTH-1:0]  row,
   output logic                        err_hit
);

   localparam logic [CW-1:0] FIRST = CW'(LANE);
   localparam logic [CW-1:0] SPAN  = CW'(SIZE);

   logic [CW-1:0]   col;
   logic            live;
   logic [SIZE-1:0] we;

   // beat < FIRST wraps col to >= 2**CW - LANE >= SIZE, so a single
   // unsigned compare covers both ends of the live window.
   always_comb begin
      col     = beat - FIRST;
      live    = col < SPAN;
      err_hit = accept && !live && (lane_data != '0);
      we      = '0;
      for (int unsigned c = 0; c < SIZE; c++) begin
         we[c] = accept && live && (col == CW'(c));
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         row <= '0;
      end else begin
         for (int unsigned c = 0; c < SIZE; c++) begin
            if (we[c]) row[c] <= lane_data;
         end
      end
   end

endmodule

// File: rtl/deskew_matrix.sv
// Reassembles 2*SIZE-1 diagonal wavefront beats into a SIZE x SIZE matrix
// and presents it with a valid/ready handshake.
module deskew_matrix
   import deskew_matrix_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SIZE  = 3
) (
   input  logic             clock,
   input  logic             nreset,
   deskew_matrix_if.slave   bus
);

   localparam int            NBEATS = beats(SIZE);
   localparam int            CW     = $clog2(NBEATS);
   localparam logic [CW-1:0] LAST   = CW'(NBEATS - 1);

   state_t                                state;
   state_t                                next_state;
   logic [CW-1:0]                         beat;
   logic                                  accept;
   logic                                  in_ready_c;
   logic                                  out_valid_c;
   logic                                  frame_err;
   logic [SIZE-1:0]                       err_hit;
   logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  rows;

   always_comb begin
      next_state  = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      accept      = 1'b0;
      unique case (state)
         COLLECT: begin
            in_ready_c = 1'b1;
            accept     = bus.in_valid;
            if (accept && beat == LAST) next_state = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) next_state = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) state <= COLLECT;
      else         state <= next_state;
   end

   // Counter parks on LAST through DONE and clears on the output handshake.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         beat <= '0;
      end else if (accept && beat != LAST) begin
         beat <= beat + 1'b1;
      end else if (state == DONE && bus.out_ready) begin
         beat <= '0;
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)        frame_err <= 1'b0;
      else if (|err_hit)  frame_err <= 1'b1;
   end

   for (genvar t = 0; t < SIZE; t++) begin : g_lane
      deskew_matrix_lane #(
         .WIDTH (WIDTH),
         .SIZE  (SIZE),
         .LANE  (t),
         .CW    (CW)
      ) u_lane (
         .clock     (clock),
         .nreset    (nreset),
         .accept    (accept),
         .beat      (beat),
         .lane_data (bus.in_beat[lane_lsb(t, WIDTH) +: WIDTH]),
         .row       (rows[t]),
         .err_hit   (err_hit[t])
      );
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.Mout      = rows;
   assign bus.frame_err = frame_err;

endmodule
